// File: rtl/l1_mmu_arbiter.sv
// l1_mmu_arbiter
//   Shares the single MMU line-transfer port between the L1 icache (read-only)
//   and the L1 dcache (read/write). One requester is granted for exactly one
//   MMU transaction. Its request is passed straight through to the MMU, and
//   mmu_done is routed back to it alone. The MMU read line is broadcast to
//   both caches.
//
//   Ports
//     sys_clk, rst        clock; asynchronous active-high reset
//     ic_req_read/addr    icache line-read request (held until ic_done)
//     ic_done             icache transaction complete, 1-cycle pulse
//     dc_req_read/write   dcache read / write request
//     dc_req_addr         dcache request address
//     dc_write_data       dcache write line
//     dc_done             dcache transaction complete, 1-cycle pulse
//     rd_data             mmu_read_data broadcast to both caches
//     mmu_req_*           request to the MMU (read, write, addr, write line)
//     mmu_done            MMU transaction complete
//     mmu_read_data       MMU read line
//     timeout_err         sticky: a grant waited MAX_WAIT cycles without done
//
//   Configuration macro ARB_ROUND_ROBIN_EN:
//     defined   - on simultaneous requests, grant the requester that was not
//                 served last
//     undefined - fixed priority, dcache wins ties
module l1_mmu_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int LINE_W   = 256,
  parameter int MAX_WAIT = 1023
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              ic_req_read,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_done,
  input  logic              dc_req_read,
  input  logic              dc_req_write,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic [LINE_W-1:0] dc_write_data,
  output logic              dc_done,
  output logic [LINE_W-1:0] rd_data,
  output logic              mmu_req_read,
  output logic              mmu_req_write,
  output logic [ADDR_W-1:0] mmu_req_addr,
  output logic [LINE_W-1:0] mmu_write_data,
  input  logic              mmu_done,
  input  logic [LINE_W-1:0] mmu_read_data,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IC = 2'd1,
    GNT_DC = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               last_dc_q, last_dc_d;   // 0 = icache served last, 1 = dcache
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               timeout_err_q, timeout_err_d;
  logic               ic_req, dc_req;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == MAX_CNT) return v;
    return v + 1'b1;
  endfunction

  assign ic_req = ic_req_read;
  assign dc_req = dc_req_read | dc_req_write;

  // Next-state / control
  always_comb begin
    state_d       = state_q;
    last_dc_d     = last_dc_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      IDLE: begin
        if (ic_req && dc_req) begin
`ifdef ARB_ROUND_ROBIN_EN
          state_d = last_dc_q ? GNT_IC : GNT_DC;
`else
          state_d = GNT_DC;
`endif
          wait_cnt_d = '0;
        end else if (dc_req) begin
          state_d    = GNT_DC;
          wait_cnt_d = '0;
        end else if (ic_req) begin
          state_d    = GNT_IC;
          wait_cnt_d = '0;
        end
      end
      GNT_IC: begin
        if (mmu_done) begin
          state_d   = HOLD;
          last_dc_d = 1'b0;
        end else if (!ic_req) begin
          // requester gave up: abort without a done pulse
          state_d = IDLE;
        end
      end
      GNT_DC: begin
        // a write->read switch keeps dc_req high, so it stays one grant
        if (mmu_done) begin
          state_d   = HOLD;
          last_dc_d = 1'b1;
        end else if (!dc_req) begin
          state_d = IDLE;
        end
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Watchdog counts every granted cycle that passes without mmu_done;
    // it only flags the error and never breaks the grant.
    if ((state_q == GNT_IC || state_q == GNT_DC) && !mmu_done) begin
      wait_cnt_d = sat_inc(wait_cnt_q);
      if (wait_cnt_d == MAX_CNT) timeout_err_d = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      last_dc_q     <= 1'b0;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_dc_q     <= last_dc_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Grant-steered pass-through to the MMU and done routing
  always_comb begin
    mmu_req_read   = 1'b0;
    mmu_req_write  = 1'b0;
    mmu_req_addr   = '0;
    mmu_write_data = '0;
    ic_done        = 1'b0;
    dc_done        = 1'b0;
    case (state_q)
      GNT_IC: begin
        mmu_req_read = ic_req_read;
        mmu_req_addr = ic_req_addr;
        ic_done      = mmu_done;
      end
      GNT_DC: begin
        mmu_req_read   = dc_req_read;
        mmu_req_write  = dc_req_write;
        mmu_req_addr   = dc_req_addr;
        mmu_write_data = dc_write_data;
        dc_done        = mmu_done;
      end
      default: ;
    endcase
  end

  assign rd_data     = mmu_read_data;
  assign timeout_err = timeout_err_q;

endmodule
